// File: rtl/pixel_writer_if.sv
// pixel_writer_if
//   Pixel stream handshake between a pixel source (line drawer) and the
//   pixel_writer sink.
//   x, y       : pixel column / row (11 bits each)
//   color      : pixel value
//   pix_valid  : source presents a pixel
//   pix_ready  : sink accepts the pixel this cycle
interface pixel_writer_if;
  logic [10:0] x;
  logic [10:0] y;
  logic        color;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output x, y, color, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  x, y, color, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/pixel_writer.sv
// pixel_writer
//   Buffers (x, y, color) pixels in a small FIFO and turns each in-range
//   pixel into one framebuffer write (addr = y*H_RES + x). Out-of-range
//   pixels are accepted and counted, never written. A clear request drains
//   the FIFO and then sweeps every framebuffer address with data 0.
//
//   state           | meaning
//   RUN             | normal operation, one FIFO pop per cycle
//   DRAIN_FOR_CLEAR | clear requested, input blocked, finishing queued pixels
//   CLEAR           | sweeping all addresses with 0, then pulse clear_done
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   pix         : pixel stream (slave side)
//   clear       : request full-screen clear
//   fb_we/fb_addr/fb_data : registered framebuffer write port
//   busy        : any work queued, in flight, or clear outstanding
//   clear_done  : one-cycle pulse after the last sweep write
//   drop_count  : saturating count of discarded out-of-range pixels
module pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  pixel_writer_if.slave     pix,
  input  logic              clear,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_data,
  output logic              busy,
  output logic              clear_done,
  output logic [15:0]       drop_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [10:0]       X_LIM     = 11'(H_RES);
  localparam logic [10:0]       Y_LIM     = 11'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
  // One bit wider than the address so the terminal value H_RES*V_RES fits.
  localparam logic [ADDR_W:0]   SWEEP_END = (ADDR_W+1)'(H_RES * V_RES);

  typedef enum logic [1:0] {RUN, DRAIN_FOR_CLEAR, CLEAR} state_t;

  state_t              state_q, state_d;
  logic                clr_pend_q, clr_pend_d;
  logic [ADDR_W:0]     sweep_q, sweep_d;
  logic [ADDR_W-1:0]   mem_addr_q [FIFO_DEPTH];
  logic                mem_color_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                fb_we_d, fb_data_d, clear_done_d;
  logic [ADDR_W-1:0]   fb_addr_d;
  logic [15:0]         drop_d;
  logic                fifo_empty, fifo_full, in_range, xfer, push, pop;
  logic [ADDR_W-1:0]   push_addr;

  assign fifo_empty    = (cnt_q == '0);
  assign fifo_full     = (cnt_q == FULL_CNT);
  assign pix.pix_ready = !reset && !fifo_full && !clr_pend_q && (state_q != CLEAR);
  assign in_range      = (pix.x < X_LIM) && (pix.y < Y_LIM);
  assign xfer          = pix.pix_valid && pix.pix_ready;
  assign push          = xfer && in_range;
  // Address is formed at push time so the FIFO stores only what the write needs.
  assign push_addr     = ADDR_W'(pix.y) * H_RES_A + ADDR_W'(pix.x);
  assign busy          = !fifo_empty || fb_we || (state_q != RUN) || clr_pend_q;

  always_comb begin
    state_d      = state_q;
    clr_pend_d   = clr_pend_q;
    sweep_d      = sweep_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr;
    fb_data_d    = fb_data;
    clear_done_d = 1'b0;
    pop          = 1'b0;
    drop_d       = drop_count;
    cnt_d        = cnt_q;

    if (xfer && !in_range && (drop_count != 16'hFFFF))
      drop_d = drop_count + 16'd1;

    unique case (state_q)
      RUN, DRAIN_FOR_CLEAR: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          fb_we_d   = 1'b1;
          fb_addr_d = mem_addr_q[rd_ptr_q];
          fb_data_d = mem_color_q[rd_ptr_q];
        end
        if (state_q == RUN) begin
          if (clear) begin
            clr_pend_d = 1'b1;
            state_d    = DRAIN_FOR_CLEAR;
          end
        end else if (fifo_empty && !fb_we) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        if (sweep_q == SWEEP_END) begin
          clear_done_d = 1'b1;
          clr_pend_d   = 1'b0;
          state_d      = RUN;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = sweep_q[ADDR_W-1:0];
          fb_data_d = 1'b0;
          sweep_d   = sweep_q + (ADDR_W+1)'(1);
        end
      end
      default: state_d = RUN;
    endcase

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      clr_pend_q <= 1'b0;
      sweep_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= 1'b0;
      clear_done <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      sweep_q    <= sweep_d;
      cnt_q      <= cnt_d;
      fb_we      <= fb_we_d;
      fb_addr    <= fb_addr_d;
      fb_data    <= fb_data_d;
      clear_done <= clear_done_d;
      drop_count <= drop_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q]  <= push_addr;
      mem_color_q[wr_ptr_q] <= pix.color;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;
  localparam int H     = 40;
  localparam int V     = 30;
  localparam int AW    = 19;
  localparam int DEPTH = 4;
  localparam int TOTAL = H * V;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          fb_we, fb_data, busy, clear_done;
  logic [AW-1:0] fb_addr;
  logic [15:0]   drop_count;

  pixel_writer_if pif();

  pixel_writer #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .pix(pif.slave), .clear(clear),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .clear_done(clear_done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;

  int  tests = 0, fails = 0;
  int  cyc = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  exp_drop = 0;
  int  done_cnt = 0, done_cyc = 0;
  bit  done_prev = 0, done_long = 0;
  int  stalls = 0;
  int  acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we === 1'b1) got_q.push_back('{int'(fb_addr), int'(fb_data), cyc});
    if (clear_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (done_prev) done_long = 1;
    end
    done_prev = clear_done;
  end

  // Reference model: in-range pixels become writes at y*H+x in acceptance
  // order; out-of-range pixels bump a saturating drop counter.
  task automatic push_pix(input int px, input int py, input bit pc);
    int guard;
    guard = 0;
    @(negedge clk);
    pif.x = 11'(px); pif.y = 11'(py); pif.color = pc; pif.pix_valid = 1'b1;
    while (!pif.pix_ready && guard < 2000) begin
      stalls++; guard++;
      @(negedge clk);
    end
    if (!pif.pix_ready) begin
      tests++; fails++;
      $display("FAIL push_timeout: pix_ready=%0b, required 1", pif.pix_ready);
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (px < H && py < V) exp_q.push_back('{py * H + px, int'(pc), 0});
      else if (exp_drop < 65535) exp_drop++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    pif.pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 5000) begin g++; @(negedge clk); end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_timeout: busy=%0b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pif.pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (pif.pix_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %0b, required 0", pif.pix_ready); end
    reset = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    tests++;
    if (pif.pix_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %0b, required 1", pif.pix_ready); end
    tests++;
    if (fb_we !== 1'b0 || fb_addr !== '0 || fb_data !== 1'b0) begin
      fails++; $display("FAIL reset_fb: we=%0b addr=%0d data=%0b, required 0/0/0", fb_we, fb_addr, fb_data);
    end
    tests++;
    if (busy !== 1'b0 || clear_done !== 1'b0 || drop_count !== 16'd0) begin
      fails++; $display("FAIL reset_status: busy=%0b done=%0b drops=%0d, required 0/0/0", busy, clear_done, drop_count);
    end
  endtask

  task automatic test_single();
    int acc;
    got_q.delete(); exp_q.delete();
    push_pix(3, 2, 1'b1);
    acc = acc_cyc;
    idle();
    wait_idle("single");
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL single_count: got %0d writes, required 1", got_q.size());
    end else begin
      tests++;
      if (got_q[0].addr !== exp_q[0].addr || got_q[0].data !== exp_q[0].data) begin
        fails++; $display("FAIL single_write: addr=%0d data=%0d, required %0d/%0d", got_q[0].addr, got_q[0].data, exp_q[0].addr, exp_q[0].data);
      end
      tests++;
      if (got_q[0].cyc !== acc + 1) begin
        fails++; $display("FAIL single_latency: write cycle %0d, required %0d", got_q[0].cyc, acc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++) push_pix(i, 0, i[0]);
    idle();
    wait_idle("b2b");
    tests++;
    if (stalls != 0) begin fails++; $display("FAIL b2b_ready_drop: %0d stalls, required 0", stalls); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data || got_q[i].cyc !== got_q[0].cyc + i) begin
        fails++; $display("FAIL b2b_write%0d: addr=%0d data=%0d cyc=%0d, required %0d/%0d cyc %0d", i,
                          got_q[i].addr, got_q[i].data, got_q[i].cyc, exp_q[i].addr, exp_q[i].data, got_q[0].cyc + i);
      end
    end
  endtask

  task automatic test_range();
    got_q.delete(); exp_q.delete();
    push_pix(H - 1, V - 1, 1'b1);
    push_pix(H, 0, 1'b1);
    push_pix(0, V, 1'b1);
    idle();
    wait_idle("range");
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL range_count: got %0d writes, required 1", got_q.size());
    end else begin
      tests++;
      if (got_q[0].addr !== exp_q[0].addr || got_q[0].data !== 1) begin
        fails++; $display("FAIL range_write: addr=%0d data=%0d, required %0d/1", got_q[0].addr, got_q[0].data, exp_q[0].addr);
      end
    end
    tests++;
    if (int'(drop_count) !== exp_drop) begin fails++; $display("FAIL range_drops: got %0d, required %0d", drop_count, exp_drop); end
  endtask

  task automatic test_random();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      push_pix(int'($urandom_range(0, H + 3)), int'($urandom_range(0, V + 2)), 1'($urandom_range(0, 1)));
    end
    idle();
    wait_idle("random");
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL random_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
        fails++; $display("FAIL random_write%0d: addr=%0d data=%0d, required %0d/%0d", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    tests++;
    if (int'(drop_count) !== exp_drop) begin fails++; $display("FAIL random_drops: got %0d, required %0d", drop_count, exp_drop); end
  endtask

  task automatic test_clear();
    int d0, g;
    got_q.delete(); exp_q.delete();
    d0 = done_cnt; done_long = 0;
    for (int i = 0; i < 3; i++) push_pix(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 1'b1);
    @(negedge clk);
    pif.pix_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (pif.pix_ready !== 1'b0) begin fails++; $display("FAIL clear_ready_drop: got %0b, required 0", pif.pix_ready); end
    for (int a = 0; a < TOTAL; a++) exp_q.push_back('{a, 0, 0});
    g = 0;
    while (got_q.size() < 23 && g < 500) begin g++; @(negedge clk); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    g = 0;
    while (done_cnt == d0 && g < 3 * TOTAL) begin g++; @(negedge clk); end
    repeat (TOTAL / 4) @(negedge clk);
    tests++;
    if (done_cnt !== d0 + 1 || done_long) begin
      fails++; $display("FAIL clear_done_pulses: got %0d pulses long=%0b, required 1 long=0", done_cnt - d0, done_long);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL clear_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
        fails++; $display("FAIL clear_write%0d: addr=%0d data=%0d, required %0d/%0d", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    if (got_q.size() > 0) begin
      tests++;
      if (done_cyc !== got_q[got_q.size() - 1].cyc + 1) begin
        fails++; $display("FAIL clear_done_timing: pulse cycle %0d, required %0d", done_cyc, got_q[got_q.size() - 1].cyc + 1);
      end
    end
    tests++;
    if (pif.pix_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL clear_after: ready=%0b busy=%0b, required 1/0", pif.pix_ready, busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    int d0, g;
    got_q.delete(); exp_q.delete();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    g = 0;
    while (got_q.size() < TOTAL / 2 && g < 3 * TOTAL) begin g++; @(negedge clk); end
    reset = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    tests++;
    if (fb_we !== 1'b0 || fb_addr !== '0 || busy !== 1'b0) begin
      fails++; $display("FAIL midclear_reset: we=%0b addr=%0d busy=%0b, required 0/0/0", fb_we, fb_addr, busy);
    end
    reset = 1'b0;
    exp_drop = 0;
    got_q.delete();
    repeat (TOTAL + 20) @(negedge clk);
    tests++;
    if (done_cnt !== d0 || got_q.size() != 0) begin
      fails++; $display("FAIL midclear_abandon: %0d pulses %0d writes, required 0/0", done_cnt - d0, got_q.size());
    end
    push_pix(1, 1, 1'b1);
    idle();
    wait_idle("midclear");
    tests++;
    if (got_q.size() != 1 || got_q[0].addr !== exp_q[0].addr || got_q[0].data !== 1) begin
      fails++; $display("FAIL midclear_pixel: %0d writes first addr=%0d, required 1 write at %0d",
                        got_q.size(), (got_q.size() > 0) ? got_q[0].addr : -1, exp_q[0].addr);
    end
  endtask

  task automatic test_drop_saturation();
    int start;
    start = exp_drop;
    for (int i = 0; i < 65534 - start; i++) push_pix(H, 0, 1'b0);
    tests++;
    if (int'(drop_count) !== exp_drop) begin fails++; $display("FAIL sat_below: got %0d, required %0d", drop_count, exp_drop); end
    push_pix(H + 1, V, 1'b0);
    tests++;
    if (int'(drop_count) !== exp_drop) begin fails++; $display("FAIL sat_reach: got %0d, required %0d", drop_count, exp_drop); end
    push_pix(0, V + 5, 1'b0);
    push_pix(H + 2, 3, 1'b0);
    idle();
    tests++;
    if (drop_count !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %0d, required 65535", drop_count); end
  endtask

  initial begin
    pif.x = '0; pif.y = '0; pif.color = 1'b0; pif.pix_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_range();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_drop_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pixel_writer.md
# pixel_writer

Receiving end of the line drawer's pixel stream. Accepts (x, y, color) pixels through a valid/ready handshake, buffers them in a small FIFO, and turns each in-range pixel into one framebuffer write (linear address, data, write enable) toward the VGA framebuffer RAM. Also provides a full-screen clear sweep so the top level can erase before redrawing. Sits between `line_drawer` (or any pixel source) and the framebuffer write port.

## Interface
- `H_RES`, 640, visible columns; x ≥ H_RES is out of range
- `V_RES`, 480, visible rows; y ≥ V_RES is out of range
- `FIFO_DEPTH`, 4, pixel buffer entries (power of two, ≥ 2)
- `ADDR_W`, 19, framebuffer address width (must hold H_RES*V_RES−1)

Ports:
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  synchronous, active-high
- `x`  in  11  pixel column
- `y`  in  11  pixel row
- `color`  in  1  pixel value to write
- `pix_valid`  in  1  source has a pixel on x/y/color
- `pix_ready`  out  1  block accepts the pixel this cycle
- `clear`  in  1  request full-screen clear (sampled each cycle)
- `fb_we`  out  1  framebuffer write enable
- `fb_addr`  out  ADDR_W  framebuffer address = y*H_RES + x
- `fb_data`  out  1  framebuffer write data
- `busy`  out  1  FIFO non-empty, write pending, or clear pending/active
- `clear_done`  out  1  one-cycle pulse when clear sweep finishes
- `drop_count`  out  16  saturating count of discarded out-of-range pixels

## Operation
- Transfer occurs on a rising edge where `pix_valid && pix_ready`; x/y/color are pushed into the FIFO at that edge.
- `pix_ready` = FIFO not full AND no clear pending AND state ≠ CLEAR. Combinational from registered state only, never from `pix_valid`.
- Out-of-range pixels (x ≥ H_RES or y ≥ V_RES) are accepted (handshake completes) but never pushed; `drop_count` increments by 1, saturating at 16'hFFFF.
- States: RUN, DRAIN_FOR_CLEAR, CLEAR.
  - RUN: when FIFO non-empty, pop one entry per cycle; register `fb_we`=1, `fb_addr`=y*H_RES+x (computed at ADDR_W bits, no truncation for in-range values), `fb_data`=color. Otherwise `fb_we`=0.
  - `clear`=1 in RUN latches a clear-pending flag; `pix_ready` drops the next cycle. State moves to DRAIN_FOR_CLEAR.
  - DRAIN_FOR_CLEAR: continue popping as RUN; when FIFO empty and no write in flight, go to CLEAR with sweep counter = 0.
  - CLEAR: each cycle `fb_we`=1, `fb_addr`=counter, `fb_data`=0, counter+1. After address H_RES*V_RES−1 is written, pulse `clear_done` for exactly one cycle, clear pending flag, return to RUN.
  - `clear` asserted while in DRAIN_FOR_CLEAR or CLEAR is ignored (no restart, no queued second clear).
- FIFO: push and pop in the same cycle allowed when non-empty; occupancy unchanged. No push when full (guaranteed by `pix_ready`). Pointers wrap modulo FIFO_DEPTH.
- `busy` = FIFO non-empty OR `fb_we` OR state ≠ RUN OR clear pending.

## Timing
- Reset (synchronous): FIFO emptied, state RUN, `fb_we`=0, `fb_addr`=0, `fb_data`=0, `busy`=0, `clear_done`=0, `drop_count`=0, clear-pending=0. `pix_ready`=0 while `reset` is high; 1 in the first cycle after reset deasserts.
- Reset mid-clear or mid-drain: abandons the operation immediately; no `clear_done` pulse; FIFO contents discarded.
- Latency: pixel accepted at edge N into an empty FIFO → `fb_we`=1 with its address during the cycle after edge N+1 (pop at N+1, registered write visible after N+1).
- Throughput: one framebuffer write per cycle sustained; with continuous valid input, `pix_ready` stays high.
- Clear duration: H_RES*V_RES cycles of `fb_we`=1 (307200 at defaults); `clear_done` high in the cycle after the last sweep write.
- Writes occur in acceptance order; no reordering, no write coalescing.

## Test plan
- Reset then push (x=3, y=2, color=1) → exactly one cycle of `fb_we`=1, `fb_addr`=1283, `fb_data`=1, two edges after acceptance; `busy` returns 0.
- Push 8 back-to-back pixels (0,0)…(7,0) with `pix_valid` held → `pix_ready` never drops, 8 consecutive writes at addresses 0..7 in order.
- Hold framebuffer side unchanged but push (639,479) then (640,0) and (0,480) → one write at address 307199; `drop_count`=2; no write for dropped pixels.
- Load 3 pixels then assert `clear` for one cycle → `pix_ready`=0 next cycle, 3 pixel writes complete first, then 307200 writes of data 0 from address 0 to 307199, one `clear_done` pulse, `pix_ready`=1 after.
- Assert `reset` halfway through a clear sweep → next cycle `fb_we`=0, `fb_addr`=0, `busy`=0, no `clear_done`; a subsequent pixel (1,1) writes address 641.
- Set `drop_count` near saturation via 65537 out-of-range pushes → counter holds at 65535.
